// File: rtl/relu_seq_ctrl.sv
// relu_seq_ctrl: streams one feature map from an input buffer through ReLU into an output buffer
// start/busy/done: pass control and status; rd_en/rd_addr/rd_data: input buffer port, data one cycle after rd_en
// wr_en/wr_addr/wr_data/wr_ready: output buffer port, head of a 2-entry queue; neg_count: clipped elements this pass
module relu_seq_ctrl #(
  parameter int DATA_W = 16,
  parameter int NUM_ELEM = 36,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ready,
  output logic [ADDR_W:0]   neg_count
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(NUM_ELEM);
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
  state_t state_q, state_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, neg_q, neg_d;
  logic [1:0] cnt_q, cnt_d, occ;
  logic infl_q, infl_d, pop, push, slot, neg_in;
  logic [ADDR_W-1:0] infl_addr_q, infl_addr_d;
  logic [1:0][ADDR_W-1:0] qa_q, qa_d;
  logic [1:0][DATA_W-1:0] qd_q, qd_d;
  logic [DATA_W-1:0] relu_in;
  // sign bit set means the two's-complement value is below zero
  assign neg_in = rd_data[DATA_W-1];
  assign relu_in = neg_in ? '0 : rd_data;
  // an empty queue lets the returning read act as head directly, saving a cycle of latency
  assign wr_en = cnt_q != 2'd0 || infl_q;
  assign wr_addr = cnt_q != 2'd0 ? qa_q[0] : infl_q ? infl_addr_q : '0;
  assign wr_data = cnt_q != 2'd0 ? qd_q[0] : infl_q ? relu_in : '0;
  assign pop = wr_en && wr_ready;
  assign occ = cnt_q + {1'b0, infl_q} - {1'b0, pop};
  assign rd_en = state_q == RUN && rd_ptr_q < LAST && occ < 2'd2;
  assign rd_addr = rd_ptr_q[ADDR_W-1:0];
  assign push = infl_q && !(pop && cnt_q == 2'd0);
  assign slot = cnt_q[0] ^ pop;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign neg_count = neg_q;
  always_comb begin
    state_d = state_q;
    rd_ptr_d = rd_en ? rd_ptr_q + ONE : rd_ptr_q;
    wr_ptr_d = pop ? wr_ptr_q + ONE : wr_ptr_q;
    neg_d = infl_q && neg_in ? neg_q + ONE : neg_q;
    cnt_d = occ;
    infl_d = rd_en;
    infl_addr_d = rd_en ? rd_addr : infl_addr_q;
    qa_d = pop ? {qa_q[1], qa_q[1]} : qa_q;
    qd_d = pop ? {qd_q[1], qd_q[1]} : qd_q;
    if (push) begin
      qa_d[slot] = infl_addr_q;
      qd_d[slot] = relu_in;
    end
    if (state_q == IDLE && start) begin
      state_d = RUN;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      neg_d = '0;
    end else if (state_q == RUN && wr_ptr_d == LAST) begin
      state_d = DONE;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      neg_q <= '0;
      cnt_q <= '0;
      infl_q <= 1'b0;
      infl_addr_q <= '0;
      qa_q <= '0;
      qd_q <= '0;
    end else begin
      state_q <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      neg_q <= neg_d;
      cnt_q <= cnt_d;
      infl_q <= infl_d;
      infl_addr_q <= infl_addr_d;
      qa_q <= qa_d;
      qd_q <= qd_d;
    end
  end
  assert property (@(posedge clk) disable iff (rst) !(infl_q && cnt_q == 2'd2 && !pop) && cnt_q != 2'd3);
endmodule

// File: tb/tb_relu_seq_ctrl.sv
// tb_relu_seq_ctrl: directed passes checked every cycle against a ReLU stream model
module tb_relu_seq_ctrl;
  localparam int DW = 16, N = 36, AW = 6;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, wr_ready = 1'b1;
  logic [DW-1:0] rd_data = '0;
  logic busy, done, rd_en, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW:0] neg_count;
  relu_seq_ctrl #(.DATA_W(DW), .NUM_ELEM(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .neg_count(neg_count)
  );
  always #5 clk = ~clk;
  logic [DW-1:0] mem [N];
  logic [DW-1:0] got [N];
  int checks = 0, errors = 0, cyc = 0, start_cyc = -1000, widx = 0, ridx = 0, occ = 0;
  int dones = 0, rds = 0, exp_neg = 0, rmode = 0, pcnt = 0;
  bit full_rate = 1'b0, pend = 1'b0, stall_prev = 1'b0, man_ready = 1'b1;
  logic [AW-1:0] paddr = '0, s_addr = '0;
  logic [DW-1:0] s_data = '0;
  function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
    return $signed(v) < 0 ? '0 : v;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    rd_data = pend ? mem[paddr] : '0;
    wr_ready = rmode == 0 ? 1'b1 : rmode == 1 ? (pcnt % 4 == 0 || pcnt % 4 == 3) : man_ready;
    pcnt++;
  end
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      pend = 1'b0; stall_prev = 1'b0; widx = 0; ridx = 0; occ = 0; start_cyc = -1000;
    end else begin
      if (start && !busy) begin
        start_cyc = cyc; widx = 0; ridx = 0; occ = 0; exp_neg = 0; full_rate = rmode == 0;
        foreach (mem[i]) if ($signed(mem[i]) < 0) exp_neg++;
      end
      if (cyc == start_cyc + 1) chk("first_rd", rd_en, 1);
      if (cyc == start_cyc + 2) chk("first_wr", wr_en, 1);
      if (rd_en) begin
        chk("rd_addr", rd_addr, ridx);
        ridx++; rds++;
      end
      if (stall_prev) chk("stall_hold", {wr_en, wr_addr, wr_data}, {1'b1, s_addr, s_data});
      if (wr_en && wr_ready) begin
        chk("wr_addr", wr_addr, widx);
        if (widx < N) begin
          chk("wr_data", wr_data, relu(mem[widx]));
          got[widx] = wr_data;
        end
        widx++;
      end
      occ += int'(rd_en) - int'(wr_en && wr_ready);
      chk("occupancy", occ > 2 || occ < 0, 0);
      if (done) begin
        dones++;
        chk("done_writes", widx, N);
        chk("neg_count", neg_count, exp_neg);
        if (full_rate) chk("done_cycle", cyc - start_cyc, 38);
      end
      stall_prev = wr_en && !wr_ready; s_addr = wr_addr; s_data = wr_data;
      pend = rd_en; paddr = rd_addr;
    end
  end
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask
  task automatic wait_done(input string nm);
    int d0 = dones;
    for (int i = 0; i < 300 && dones == d0; i++) begin
      @(negedge clk); #1;
    end
    chk(nm, dones - d0, 1);
  endtask
  initial begin
    int d0, r0;
    repeat (2) @(posedge clk);
    #1 chk("reset_outs", {busy, done, rd_en, wr_en, rd_addr, wr_addr, wr_data, neg_count}, 0);
    rst = 1'b0;
    foreach (mem[i]) mem[i] = DW'(i - 18);
    pulse_start();
    wait_done("ramp_done");
    chk("ramp_got0", got[0], 0);
    chk("ramp_got18", got[18], 0);
    chk("ramp_got19", got[19], 1);
    chk("ramp_got35", got[35], 17);
    chk("ramp_neg", neg_count, 18);
    foreach (mem[i]) mem[i] = DW'($urandom);
    d0 = dones;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("busy_start_done");
    repeat (5) @(posedge clk);
    chk("single_done", dones - d0, 1);
    foreach (mem[i]) mem[i] = DW'($urandom);
    rmode = 1;
    pulse_start();
    wait_done("pattern_done");
    foreach (mem[i]) mem[i] = DW'((i * 977) ^ (i << 13));
    rmode = 2; man_ready = 1'b0;
    repeat (2) @(posedge clk);
    r0 = rds;
    pulse_start();
    repeat (10) @(negedge clk);
    #1 chk("stall_reads", rds - r0, 2);
    chk("stall_head", {wr_en, wr_addr}, {1'b1, 6'd0});
    man_ready = 1'b1;
    wait_done("stall_done");
    rmode = 0;
    foreach (mem[i]) mem[i] = 16'h0005;
    mem[0] = 16'h8000; mem[1] = 16'hFFFF; mem[2] = 16'h0000; mem[3] = 16'h7FFF; mem[4] = 16'h0001;
    pulse_start();
    wait_done("bound_done");
    chk("bound_8000", got[0], 0);
    chk("bound_ffff", got[1], 0);
    chk("bound_0000", got[2], 0);
    chk("bound_7fff", got[3], 16'h7FFF);
    chk("bound_0001", got[4], 1);
    chk("bound_neg", neg_count, 2);
    foreach (mem[i]) mem[i] = DW'($urandom);
    pulse_start();
    for (int i = 0; i < 100 && widx < 20; i++) begin
      @(negedge clk); #1;
    end
    chk("reach_elem20", widx >= 20, 1);
    @(posedge clk); #1 rst = 1'b1;
    #1 chk("midrst_outs", {busy, done, rd_en, wr_en, rd_addr, wr_addr, wr_data, neg_count}, 0);
    @(posedge clk); #1 rst = 1'b0;
    foreach (mem[i]) mem[i] = DW'(i - 18);
    pulse_start();
    wait_done("after_rst_done");
    chk("after_rst_neg", neg_count, 18);
    chk("after_rst_got35", got[35], 17);
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/relu_seq_ctrl.md
Name: relu_seq_ctrl

Overview:
- Sequencer that streams one NUM_ELEM-element feature map (default 6x6 = 36, row-major) from an input buffer, applies ReLU one element at a time, and writes the results to an output buffer.
- Sits between the conv output buffer and the pooling stage.
- Issues buffer reads, absorbs the 1-cycle read latency, and honours downstream backpressure through a 2-entry output queue.
- Reports clipped-element count and start/busy/done status.

Parameters:
DATA_W, 16, signed element width
NUM_ELEM, 36, elements per feature map
ADDR_W, 6, buffer address width; must satisfy 2**ADDR_W >= NUM_ELEM

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins a pass when idle
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse after the final write is accepted
rd_en  output  1  input-buffer read strobe
rd_addr  output  ADDR_W  input-buffer address
rd_data  input  DATA_W  signed read data, valid the cycle after rd_en
wr_en  output  1  output-buffer write valid (head of queue)
wr_addr  output  ADDR_W  output-buffer address
wr_data  output  DATA_W  ReLU result
wr_ready  input  1  sink accepts the write when wr_en && wr_ready
neg_count  output  ADDR_W+1  number of elements clipped in the current or last pass

Behaviour:
- Reset (async): FSM=IDLE. busy, done, rd_en, wr_en = 0. rd_addr, wr_addr, wr_data, neg_count = 0. Queue is empty and in-flight flag clear.
- States:
  - IDLE: start=1 -> RUN. rd_ptr, wr_ptr and neg_count clear.
  - RUN: wr_ptr reaches NUM_ELEM, meaning the last write was accepted -> DONE.
  - DONE: lasts one cycle, done=1 -> IDLE.
- start is ignored outside IDLE.
- busy=1 exactly in RUN and DONE.
- Read issue:
  - rd_en=1 in RUN when rd_ptr<NUM_ELEM and (queue occupancy + in-flight read − write accepted this cycle) < 2.
  - rd_addr=rd_ptr; rd_ptr increments on each rd_en.
  - rd_en is combinational on state, pointer and occupancy. It does not depend on rd_data.
- Read return:
  - The cycle after rd_en, rd_data is captured into the queue tail with the ReLU applied: value<0 -> 0, otherwise unchanged (signed compare).
  - Address tag = read address. neg_count increments when value<0.
- Write:
  - wr_en = queue non-empty. wr_addr and wr_data come from the queue head.
  - On wr_en && wr_ready the head pops and wr_ptr increments.
  - Head contents are held stable while wr_en=1 and wr_ready=0.
- Simultaneous push and pop is legal; occupancy is unchanged.
- The queue never overflows, by construction of the issue rule. Overflow is an assertion failure.
- Latency and throughput:
  - start at cycle T: first rd_en at T+1, first wr_en at T+2.
  - With wr_ready held at 1: one element per cycle; last write at T+NUM_ELEM+1; done at T+NUM_ELEM+2; IDLE at T+NUM_ELEM+3.
  - Back-to-back start is accepted in the IDLE cycle after DONE.
- Backpressure: wr_ready=0 stalls issue after at most 2 buffered elements. Order and addresses are preserved.
- neg_count holds its value after done until the next accepted start.
- Reset mid-pass: immediate return to the reset state. A partially written output buffer is not cleaned up.
- The value 0 passes through as 0. Maximum positive 0x7FFF passes unchanged. 0x8000 -> 0.

Test Plan:
- Reset, then start with input[i]=i−18 and wr_ready=1 -> 36 writes in order, addr 0..35; data 0 for i<=18, i−18 otherwise; neg_count=18; done pulse exactly 38 cycles after start.
- Start while busy (pulse at T+5) -> ignored; exactly 36 writes and one done pulse.
- wr_ready toggled 1,0,0,1 repeating, random data -> output matches the ReLU golden model, addresses are monotonic, at most 2 reads are outstanding or buffered, wr_data is stable during stalls.
- wr_ready=0 from start for 10 cycles -> exactly 2 rd_en pulses, then none; wr_en=1 with addr 0 held; resumes correctly once wr_ready=1.
- Boundary data {0x8000, 0xFFFF, 0x0000, 0x7FFF, ...} -> {0, 0, 0, 0x7FFF}; neg_count counts only negatives.
- Assert rst at element 20 mid-pass -> all outputs are 0 within the same cycle; a new start afterwards runs a clean full pass with neg_count restarted from 0.
